// File: rtl/decode_execute_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU class codes, opcodes and the packed control word.
package decode_execute_stage_pkg;

  localparam logic [1:0] ALU_OP_LOAD_STORE = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH     = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE      = 2'b10;
  localparam logic [1:0] ALU_OP_JUMP       = 2'b11;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic       d_cache_access;
    logic       d_cache_op;
    logic       branch;
    logic       reg_write;
    logic       alu_src;
    logic       is_imm;
    logic       is_byte_op;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_execute_stage_hazard_detect.sv
// Load-use hazard equation between the instruction in decode and a load sitting in execute.
module hazard_detect
  import decode_execute_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_alu_src,
  input  logic                  id_d_cache_access,
  input  logic                  id_d_cache_op,
  input  logic                  ex_valid,
  input  logic                  ex_d_cache_access,
  input  logic                  ex_d_cache_op,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard
);

  logic load_in_ex;
  logic rs2_used;

  assign load_in_ex = ex_valid & ex_d_cache_access & ex_d_cache_op & ex_reg_write;
  // rs2 is a real source for register-register ops and for store data, not for ALU-immediate forms.
  assign rs2_used   = ~id_alu_src | (id_d_cache_access & ~id_d_cache_op);
  assign hazard     = id_valid & load_in_ex & (ex_rd != '0) &
                      ((id_rs1 == ex_rd) | (rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register with load-use bubble insertion, execute back-pressure and flush.
module decode_execute_stage
  import decode_execute_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_d_cache_access,
  input  logic                  id_d_cache_op,
  input  logic                  id_branch,
  input  logic                  id_reg_write,
  input  logic                  id_alu_src,
  input  logic                  id_is_imm,
  input  logic                  id_is_byte_op,
  input  logic [1:0]            id_alu_op,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_pc,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic                  ex_d_cache_access,
  output logic                  ex_d_cache_op,
  output logic                  ex_branch,
  output logic                  ex_reg_write,
  output logic                  ex_alu_src,
  output logic                  ex_is_imm,
  output logic                  ex_is_byte_op,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc
);

  ctrl_t                  id_ctrl;
  ctrl_t                  ctrl_p1;
  logic                   vld_p1;
  logic [REG_ADDR_W-1:0]  rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0]        rs1_data_p1, rs2_data_p1, imm_p1, pc_p1;
  logic                   hazard;

  assign id_ctrl = '{d_cache_access: id_d_cache_access, d_cache_op: id_d_cache_op,
                     branch: id_branch, reg_write: id_reg_write, alu_src: id_alu_src,
                     is_imm: id_is_imm, is_byte_op: id_is_byte_op, alu_op: id_alu_op};

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_alu_src        (id_alu_src),
    .id_d_cache_access (id_d_cache_access),
    .id_d_cache_op     (id_d_cache_op),
    .ex_valid          (vld_p1),
    .ex_d_cache_access (ctrl_p1.d_cache_access),
    .ex_d_cache_op     (ctrl_p1.d_cache_op),
    .ex_reg_write      (ctrl_p1.reg_write),
    .ex_rd             (rd_p1),
    .hazard            (hazard)
  );

  assign id_stall = ex_stall | hazard;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      pc_p1       <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (ex_stall) begin
      vld_p1  <= vld_p1;
      ctrl_p1 <= ctrl_p1;
    end else if (hazard) begin
      // Bubble: data fields keep stale values since nothing downstream consumes them.
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      vld_p1      <= id_valid;
      ctrl_p1     <= id_valid ? id_ctrl : '0;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
      pc_p1       <= id_pc;
    end
  end

  assign ex_valid          = vld_p1;
  assign ex_d_cache_access = ctrl_p1.d_cache_access;
  assign ex_d_cache_op     = ctrl_p1.d_cache_op;
  assign ex_branch         = ctrl_p1.branch;
  assign ex_reg_write      = ctrl_p1.reg_write;
  assign ex_alu_src        = ctrl_p1.alu_src;
  assign ex_is_imm         = ctrl_p1.is_imm;
  assign ex_is_byte_op     = ctrl_p1.is_byte_op;
  assign ex_alu_op         = ctrl_p1.alu_op;
  assign ex_rs1            = rs1_p1;
  assign ex_rs2            = rs2_p1;
  assign ex_rd             = rd_p1;
  assign ex_rs1_data       = rs1_data_p1;
  assign ex_rs2_data       = rs2_data_p1;
  assign ex_imm            = imm_p1;
  assign ex_pc             = pc_p1;

endmodule
